// File: rtl/clk_gate_ctrl.sv
// Sequencer for the clock-gating cell of a shared gated-clock domain: round-robin
// grant, programmable wake-up delay, registered enable. Optional idle hold: CG_IDLE_HOLD_EN.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DONE,
  input  logic               FORCE_ON,
  output logic [NUM_REQ-1:0] GNT,
  output logic               CLK_EN,
  output logic               BUSY
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Reject illegal configurations at elaboration rather than misbehave in silicon.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("clk_gate_ctrl: NUM_REQ must be 2..8");
  end
  if (WAKE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
    $error("clk_gate_ctrl: WAKE_CYCLES and HOLD_CYCLES must be >= 1");
  end
  if ((2 ** CNT_W) <= WAKE_CYCLES || (2 ** CNT_W) <= HOLD_CYCLES) begin : g_bad_cnt_w
    $error("clk_gate_ctrl: CNT_W too narrow for WAKE_CYCLES/HOLD_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_GRANT,
    S_ARB
`ifdef CG_IDLE_HOLD_EN
    , S_HOLD
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               en_q, en_d;
  logic               clk_en_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] rr_pick;

  // First requester found searching from the one after the last winner, with wrap.
  function automatic logic [NUM_REQ-1:0] rr_select(input logic [NUM_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  assign rr_pick = rr_select(REQ, ptr_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves
    // one unassigned, which is what would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    en_d    = en_q;

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        en_d  = 1'b0;
        if (|REQ) begin
          state_d = S_WAKE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      S_WAKE: begin
        en_d = 1'b1;
        if (cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
          if (|REQ) begin
            state_d = S_GRANT;
            gnt_d   = rr_pick;
            ptr_d   = onehot_to_idx(rr_pick);
          end else begin
            state_d = S_ARB;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GRANT: begin
        // Only the holder's DONE releases the grant; REQ dropping is not a release.
        if (|(DONE & gnt_q)) begin
          state_d = S_ARB;
          gnt_d   = '0;
        end
      end

      S_ARB: begin
        gnt_d = '0;
        en_d  = 1'b1;
        if (|REQ) begin
          state_d = S_GRANT;
          gnt_d   = rr_pick;
          ptr_d   = onehot_to_idx(rr_pick);
        end else begin
`ifdef CG_IDLE_HOLD_EN
          state_d = S_HOLD;
          cnt_d   = '0;
`else
          state_d = S_IDLE;
          en_d    = 1'b0;
`endif
        end
      end

`ifdef CG_IDLE_HOLD_EN
      S_HOLD: begin
        en_d = 1'b1;
        // Clock is still running, so a new request skips the wake-up delay.
        if (|REQ) begin
          state_d = S_GRANT;
          gnt_d   = rr_pick;
          ptr_d   = onehot_to_idx(rr_pick);
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      en_q     <= 1'b0;
      // The debug override keeps the gated clock alive even through reset.
      clk_en_q <= FORCE_ON;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      clk_en_q <= en_d | FORCE_ON;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign GNT    = gnt_q;
  assign CLK_EN = clk_en_q;
  assign BUSY   = busy_q;

endmodule
